// File: rtl/mux_rr_channel_select.sv
// mux_rr_channel_select: registered N-to-1 channel mux with manual or round-robin selection
module mux_rr_channel_select #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [SEL_W-1:0]          rr_ptr;
  logic [SEL_W-1:0]          rr_g;
  logic                      rr_hit;
  logic [(2**SEL_W)-1:0]     valid_pad;
  logic                      man_ok;
  logic                      slot_free;
  logic                      grant;
  logic [SEL_W-1:0]          g;
  int                        idx;
  assign valid_pad = (2**SEL_W)'(in_valid);
  assign man_ok    = (int'(sel) < CHANNELS) && valid_pad[sel];
  assign slot_free = !out_valid || out_ready;
  assign grant     = rst_n && slot_free && (mode ? rr_hit : man_ok);
  assign g         = mode ? rr_g : (man_ok ? sel : '0);
  assign in_ready  = grant ? (CHANNELS'(1) << g) : '0;
  // first valid channel after rr_ptr, wrapping modulo CHANNELS
  always_comb begin
    rr_hit = 1'b0;
    rr_g   = '0;
    idx    = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(rr_ptr) + k) % CHANNELS;
      if (!rr_hit && in_valid[idx]) begin
        rr_hit = 1'b1;
        rr_g   = SEL_W'(idx);
      end
    end
  end
  // output register: load on grant, drain on consume, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= SEL_W'(CHANNELS - 1);
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(g)*WIDTH +: WIDTH];
      out_chan  <= g;
      if (mode) rr_ptr <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_rr_channel_select.sv
// tb_mux_rr_channel_select: directed plus random checks against a behavioural model
module tb_mux_rr_channel_select;
  localparam int W = 8, C = 4, S = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [C*W-1:0] in_data;
  logic [C-1:0] in_valid, in_ready;
  logic mode;
  logic [S-1:0] sel;
  logic [W-1:0] out_data;
  logic [S-1:0] out_chan;
  logic out_valid, out_ready;
  int tests = 0, fails = 0;
  int m_valid, m_data, m_chan, m_ptr, g;
  logic [W-1:0] held;
  always #5 clk = ~clk;
  mux_rr_channel_select #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int ref_grant();
    if (!(m_valid == 0 || out_ready)) return -1;
    if (mode) begin
      for (int k = 1; k <= C; k++) if (in_valid[(m_ptr + k) % C]) return (m_ptr + k) % C;
      return -1;
    end
    if (int'(sel) < C && in_valid[sel]) return int'(sel);
    return -1;
  endfunction
  task automatic model_reset();
    m_valid = 0; m_data = 0; m_chan = 0; m_ptr = C - 1;
  endtask
  task automatic step();
    #2;
    g = ref_grant();
    chk("in_ready", 32'(in_ready), g < 0 ? 32'd0 : 32'd1 << g);
    @(posedge clk); #1;
    if (g >= 0) begin
      m_valid = 1; m_data = int'(in_data[g*W +: W]); m_chan = g;
      if (mode) m_ptr = g;
    end else if (out_ready) m_valid = 0;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_chan", 32'(out_chan), 32'(m_chan));
  endtask
  initial begin
    model_reset();
    in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_chan", 32'(out_chan), 0);
    rst_n = 1'b1;
    step();
    chk("idle_valid", 32'(out_valid), 0);
    in_valid = 4'b1111; sel = 2'd2;
    step();
    chk("man_data", 32'(out_data), 32'hCC);
    chk("man_chan", 32'(out_chan), 2);
    sel = 2'd3; in_valid = 4'b0111;
    step();
    chk("man_inv_valid", 32'(out_valid), 0);
    mode = 1'b1; in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_fair_chan", 32'(out_chan), 32'(k % C));
      chk("rr_fair_data", 32'(out_data), 32'hAA + 32'h11 * 32'(k % C));
    end
    in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_skip_chan", 32'(out_chan), k % 2 == 0 ? 32'd3 : 32'd0);
    end
    held = out_data;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'($urandom);
      step();
      chk("bp_hold", 32'(out_data), 32'(held));
    end
    out_ready = 1'b1; in_valid = 4'b1111; in_data = 32'h44332211;
    step();
    chk("bp_release_valid", 32'(out_valid), 1);
    for (int k = 0; k < 400; k++) begin
      in_data = 32'($urandom);
      in_valid = 4'($urandom);
      mode = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    out_ready = 1'b0; in_valid = 4'b1111; mode = 1'b0; sel = 2'd1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_data", 32'(out_data), 0);
    chk("async_rst_chan", 32'(out_chan), 0);
    chk("async_rst_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = '0; out_ready = 1'b1;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
